tmds_decoder_dvi: RTL

Receive-side counterpart of the DVI TMDS encoder: takes one channel's 10-bit parallel words from a 1:10 deserializer, finds the word boundary by bit-slipping until control tokens are seen, and decodes each aligned word to 8-bit pixel data or a 2-bit control value with display enable. A DVI receiver instantiates one per channel. Channel 0 control carries {v_sync, h_sync}.

---
 rtl/tmds_decoder_dvi_if.sv | 20 ++
 rtl/tmds_decoder_dvi.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder_dvi_if.sv
// Word-level connection between one TMDS receive channel's deserializer and its decoder.
interface tmds_decoder_dvi_if;
  logic       i_clk_lock;
  logic [9:0] i_tmds;
  logic [7:0] o_data;
  logic [1:0] o_ctrl;
  logic       o_de;
  logic       o_locked;
  logic [3:0] o_offset;

  modport master (
    output i_clk_lock, i_tmds,
    input  o_data, o_ctrl, o_de, o_locked, o_offset
  );

  modport slave (
    input  i_clk_lock, i_tmds,
    output o_data, o_ctrl, o_de, o_locked, o_offset
  );
endinterface

// File: rtl/tmds_decoder_dvi.sv
// One DVI TMDS receive channel: bit-slip word alignment on control tokens,
// then 10b->8b data decode or 2-bit control decode with display enable.
module tmds_decoder_dvi #(
  parameter int LOCK_TOKENS = 64,
  parameter int SLIP_WAIT   = 4096
) (
  input  logic              i_pix_clk,
  input  logic              i_rst,
  tmds_decoder_dvi_if.slave bus
);
  localparam int               MAX_P     = (LOCK_TOKENS > SLIP_WAIT) ? LOCK_TOKENS : SLIP_WAIT;
  localparam int               CNT_W     = $clog2(MAX_P + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LOCK_N    = CNT_W'(LOCK_TOKENS);
  localparam logic [CNT_W-1:0] SLIP_N    = CNT_W'(SLIP_WAIT);
  localparam logic [3:0]       OFF_LAST  = 4'd9;

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Returns {hit, c1, c0} for the four control tokens.
  function automatic logic [2:0] token_lookup(input logic [9:0] q);
    logic [2:0] r;
    case (q)
      10'b1101010100: r = 3'b100;
      10'b0010101011: r = 3'b101;
      10'b0101010100: r = 3'b110;
      10'b1010101011: r = 3'b111;
      default:        r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] q);
    logic [7:0] t;
    logic [7:0] d;
    t    = q[9] ? ~q[7:0] : q[7:0];
    d[0] = t[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
    return d;
  endfunction

  state_t           state_r;
  state_t           state_n;
  logic [9:0]       prev_r;
  logic [9:0]       aligned_r;
  logic [3:0]       off_r;
  logic [3:0]       off_n;
  logic [3:0]       off_next_s;
  logic [CNT_W-1:0] tok_cnt_r;
  logic [CNT_W-1:0] tok_cnt_n;
  logic [CNT_W-1:0] timer_r;
  logic [CNT_W-1:0] timer_n;
  logic [CNT_W-1:0] tok_inc_s;
  logic [CNT_W-1:0] timer_inc_s;
  logic [CNT_W-1:0] tok_step_s;
  logic [CNT_W-1:0] timer_lk_s;
  logic [19:0]      window_s;
  logic [9:0]       slice_s;
  logic [2:0]       token_s;
  logic             is_tok_s;
  logic [7:0]       data_r;
  logic [1:0]       ctrl_r;
  logic             de_r;

  assign window_s    = {bus.i_tmds, prev_r};
  assign slice_s     = 10'(window_s >> off_r);
  assign token_s     = token_lookup(aligned_r);
  assign is_tok_s    = token_s[2];
  assign tok_inc_s   = (tok_cnt_r == CNT_MAX) ? tok_cnt_r : tok_cnt_r + CNT_ONE;
  assign timer_inc_s = (timer_r == CNT_MAX) ? timer_r : timer_r + CNT_ONE;
  assign tok_step_s  = is_tok_s ? tok_inc_s : CNT_ZERO;
  assign timer_lk_s  = is_tok_s ? CNT_ZERO : timer_inc_s;
  assign off_next_s  = (off_r == OFF_LAST) ? 4'd0 : off_r + 4'd1;

  // Alignment FSM next state: lock on a run of tokens, slip one bit on timeout.
  always_comb begin
    state_n   = state_r;
    off_n     = off_r;
    tok_cnt_n = tok_cnt_r;
    timer_n   = timer_r;
    if (!bus.i_clk_lock) begin
      state_n   = ST_SEARCH;
      tok_cnt_n = CNT_ZERO;
      timer_n   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_SEARCH: begin
          // Lock takes priority; a token arriving as the timer expires is discarded by the slip.
          if (tok_step_s >= LOCK_N) begin
            state_n   = ST_LOCKED;
            tok_cnt_n = tok_step_s;
            timer_n   = CNT_ZERO;
          end else if (timer_inc_s >= SLIP_N) begin
            off_n     = off_next_s;
            tok_cnt_n = CNT_ZERO;
            timer_n   = CNT_ZERO;
          end else begin
            tok_cnt_n = tok_step_s;
            timer_n   = timer_inc_s;
          end
        end
        ST_LOCKED: begin
          if (timer_lk_s >= SLIP_N) begin
            state_n   = ST_SEARCH;
            off_n     = off_next_s;
            tok_cnt_n = CNT_ZERO;
            timer_n   = CNT_ZERO;
          end else begin
            timer_n   = timer_lk_s;
          end
        end
        default: begin
          state_n   = ST_SEARCH;
          tok_cnt_n = CNT_ZERO;
          timer_n   = CNT_ZERO;
        end
      endcase
    end
  end

  // Input window, aligned word and alignment state registers.
  always_ff @(posedge i_pix_clk or posedge i_rst) begin
    if (i_rst) begin
      prev_r    <= 10'd0;
      aligned_r <= 10'd0;
      off_r     <= 4'd0;
      state_r   <= ST_SEARCH;
      tok_cnt_r <= CNT_ZERO;
      timer_r   <= CNT_ZERO;
    end else begin
      prev_r    <= bus.i_tmds;
      aligned_r <= slice_s;
      off_r     <= off_n;
      state_r   <= state_n;
      tok_cnt_r <= tok_cnt_n;
      timer_r   <= timer_n;
    end
  end

  // Decoded output register; enable follows the state being entered so lock loss gates it at once.
  always_ff @(posedge i_pix_clk or posedge i_rst) begin
    if (i_rst) begin
      data_r <= 8'd0;
      ctrl_r <= 2'd0;
      de_r   <= 1'b0;
    end else if (is_tok_s) begin
      data_r <= 8'd0;
      ctrl_r <= token_s[1:0];
      de_r   <= 1'b0;
    end else begin
      data_r <= tmds_decode(aligned_r);
      ctrl_r <= ctrl_r;
      de_r   <= (state_n == ST_LOCKED);
    end
  end

  assign bus.o_data   = data_r;
  assign bus.o_ctrl   = ctrl_r;
  assign bus.o_de     = de_r;
  assign bus.o_locked = (state_r == ST_LOCKED);
  assign bus.o_offset = off_r;
endmodule
